// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
//
// Purpose:
//   Output stage for the flow-LED shifter. Each bit of the incoming LED
//   pattern selects a brightness target: fully on (PWM_MAX) or off (0).
//   Every channel has a level register that ramps toward its target by
//   FADE_STEP once per fade tick. The level is turned into a per-channel PWM
//   waveform. The rotating light therefore leaves a soft trail instead of
//   switching hard. With fade_en low the ramp is bypassed and each level
//   follows its target on every clock.
//
// Parameters:
//   N_LED      number of LED channels
//   PWM_BITS   PWM resolution; PWM_MAX = 2^PWM_BITS - 1
//   FADE_DIV   sys_clk cycles per fade step (>= 1)
//   FADE_STEP  level change per fade step (1..PWM_MAX)
//
// Ports:
//   sys_clk    in   system clock; all logic on the rising edge
//   sys_rst_n  in   synchronous active-low reset
//   led_in     in   [N_LED] pattern from the flow shifter (same domain)
//   fade_en    in   1 = ramped fades, 0 = level jumps straight to target
//   led_out    out  [N_LED] registered PWM drive to the LED pins
//   busy       out  registered; 1 while fade_en=1 and any level differs
//                   from its target
// ---------------------------------------------------------------------------
module led_fade_pwm #(
  parameter int N_LED     = 6,
  parameter int PWM_BITS  = 8,
  parameter int FADE_DIV  = 50000,
  parameter int FADE_STEP = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_LED-1:0] led_in,
  input  logic             fade_en,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  // The prescaler needs at least one bit, even when FADE_DIV is 1.
  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};
  // PWM_MAX - 1 is the last count of a PWM period (the period is PWM_MAX
  // clocks). That makes duty = PWM_MAX a solid-on output.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);

  // Ramp arithmetic uses one extra bit so that a step past PWM_MAX is
  // visible and can be clamped. It must never wrap back to a low level.
  localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(FADE_STEP);
  localparam logic [PWM_BITS:0]   MAX_EXT  = {1'b0, PWM_MAX};

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [N_LED-1:0]    led_in_q;

  logic [PWM_BITS-1:0] level     [N_LED];
  logic [PWM_BITS-1:0] duty      [N_LED];
  logic [PWM_BITS-1:0] target    [N_LED];
  logic [PWM_BITS-1:0] level_nxt [N_LED];

  logic pwm_wrap;
  logic fade_tick;
  logic any_diff;

  assign pwm_wrap  = (pwm_cnt == PWM_LAST);
  assign fade_tick = (div_cnt == DIV_LAST);

  // PWM period counter and fade prescaler. Both free-run; the prescaler
  // keeps ticking during bypass, so re-enabling fades stays in phase.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pwm_cnt <= '0;
      div_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_wrap  ? '0 : pwm_cnt + 1'b1;
      div_cnt <= fade_tick ? '0 : div_cnt + 1'b1;
    end
  end

  // Register the shifter pattern once before it is used to derive targets.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      led_in_q <= '0;
    end else begin
      led_in_q <= led_in;
    end
  end

  // Per-channel target and next level. Each channel is evaluated on its own,
  // so a channel ramping up never affects a neighbour ramping down. When the
  // target reverses mid-ramp, the level simply moves the other way from
  // where it is.
  always_comb begin
    logic [PWM_BITS:0] up_sum;
    logic [PWM_BITS:0] lvl_ext;
    any_diff = 1'b0;
    up_sum   = '0;
    lvl_ext  = '0;
    for (int i = 0; i < N_LED; i++) begin
      target[i]    = led_in_q[i] ? PWM_MAX : '0;
      level_nxt[i] = level[i];
      lvl_ext      = {1'b0, level[i]};
      up_sum       = lvl_ext + STEP_EXT;

      if (level[i] != target[i]) begin
        any_diff = 1'b1;
      end

      if (!fade_en) begin
        level_nxt[i] = target[i];
      end else if (fade_tick) begin
        if (level[i] < target[i]) begin
          level_nxt[i] = (up_sum > MAX_EXT) ? PWM_MAX : up_sum[PWM_BITS-1:0];
        end else if (level[i] > target[i]) begin
          level_nxt[i] = (lvl_ext > STEP_EXT) ?
                         (level[i] - STEP_EXT[PWM_BITS-1:0]) : '0;
        end
      end
    end
  end

  // Level, duty and output registers per channel. Duty is only reloaded
  // on the last count of a period, so a ramp cannot cut a pulse short
  // mid-period. The output compares the current counter with the current
  // duty, so the output lags pwm_cnt by one clock.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_LED; i++) begin
        level[i] <= '0;
        duty[i]  <= '0;
      end
      led_out <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        level[i] <= level_nxt[i];
        if (pwm_wrap) begin
          duty[i] <= level[i];
        end
        led_out[i] <= (pwm_cnt < duty[i]);
      end
    end
  end

  // busy reports an unfinished ramp. It uses this clock's register values,
  // so it drops one clock after the last channel reaches its target. It
  // stays low throughout bypass.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= fade_en & any_diff;
    end
  end

endmodule
